counter_seq_ctrl: RTL and testbench

//  Sequencer for the WIDTH-bit up-counter datapath. It runs timed count intervals on request.
//  A start pulse latches a terminal value and runs the counter from 0 to that value.
//  The block then stops (one-shot) or wraps and repeats (periodic).

---
 rtl/counter_seq_ctrl.sv | 97 +++++++++
 tb/tb_counter_seq_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencer running a WIDTH-bit up-counter from 0 to a latched limit,
// one-shot or periodic, with pause/abort and a saturating completed-period tally.
module counter_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  limit,
  input  logic              periodic,
  input  logic              pause,
  input  logic              abort,
  output logic              busy,
  output logic [WIDTH-1:0]  cout,
  output logic              done,
  output logic              err,
  output logic [PCNT_W-1:0] period_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cout_q, cout_d, lim_q, lim_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic per_q, per_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    cout_d  = cout_q;
    lim_d   = lim_q;
    per_d   = per_q;
    pcnt_d  = pcnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && limit != '0) begin
          lim_d   = limit;
          per_d   = periodic;
          cout_d  = '0;
          pcnt_d  = '0;
          state_d = RUN;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cout_d  = '0;
        end else if (cout_q == lim_q) begin
          cout_d  = per_q ? '0 : cout_q;
          state_d = per_q ? RUN : IDLE;
          pcnt_d  = (per_q && !(&pcnt_q)) ? pcnt_q + 1'b1 : pcnt_q;
        end else if (pause) begin
          state_d = HOLD;
        end else begin
          cout_d = cout_q + 1'b1;
        end
      end
      default: begin
        if (abort) begin
          state_d = IDLE;
          cout_d  = '0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
    endcase
    busy_d = state_d != IDLE;
    // A held count is always below the limit, so only fresh RUN arrivals can hit it
    done_d = state_d == RUN && cout_d == lim_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cout_q  <= '0;
      lim_q   <= '0;
      per_q   <= 1'b0;
      pcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cout_q  <= cout_d;
      lim_q   <= lim_d;
      per_q   <= per_d;
      pcnt_q  <= pcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign busy       = busy_q;
  assign cout       = cout_q;
  assign done       = done_q;
  assign err        = err_q;
  assign period_cnt = pcnt_q;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed stimulus pushes hand-computed expected outputs into a
// scoreboard queue; a negedge monitor pops and compares one entry per cycle.
module tb_counter_seq_ctrl;
  logic clk, reset, start, periodic, pause, abort;
  logic [3:0] limit;
  logic busy, done, err;
  logic [3:0] cout;
  logic [7:0] period_cnt;
  typedef struct {
    string      nm;
    logic [14:0] v;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  counter_seq_ctrl #(.WIDTH(4), .PCNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .limit(limit), .periodic(periodic),
    .pause(pause), .abort(abort), .busy(busy), .cout(cout), .done(done), .err(err),
    .period_cnt(period_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [14:0] got;
      e = sb.pop_front();
      got = {busy, cout, done, err, period_cnt};
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s: got busy=%b cout=%0d done=%b err=%b pcnt=%0d, expected busy=%b cout=%0d done=%b err=%b pcnt=%0d",
                 e.nm, got[14], got[13:10], got[9], got[8], got[7:0],
                 e.v[14], e.v[13:10], e.v[9], e.v[8], e.v[7:0]);
      end
    end
  end

  task automatic st(input string nm, input logic s, input logic [3:0] l, input logic p,
                    input logic pa, input logic ab, input logic b, input logic [3:0] c,
                    input logic d, input logic e, input logic [7:0] pc);
    start = s; limit = l; periodic = p; pause = pa; abort = ab;
    @(posedge clk);
    sb.push_back('{nm, {b, c, d, e, pc}});
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 0; limit = 0; periodic = 0; pause = 0; abort = 0;
    st("rst_low", 1, 4'd5, 0, 0, 0, 0, 0, 0, 0, 0);
    st("rst_low", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    st("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // one-shot limit 5
    st("os5_start", 1, 4'd5, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) st("os5_run", 0, 4'd5, 0, 0, 0, 1, 4'(k), k == 5, 0, 0);
    st("os5_end", 0, 0, 0, 0, 0, 0, 4'd5, 0, 0, 0);
    st("os5_hold", 0, 0, 0, 0, 0, 0, 4'd5, 0, 0, 0);
    // periodic limit 3, abort at cout 2
    st("per3_start", 1, 4'd3, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 14; k++)
      st("per3_run", 0, 4'd3, 1, 0, 0, 1, 4'(k % 4), (k % 4) == 3, 0, 8'(k / 4));
    st("per3_abort", 0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
    st("idle_abort", 0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
    // one-shot limit 9, pause 3 cycles at cout 4 then one resume cycle
    st("os9_start", 1, 4'd9, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) st("os9_run", 0, 0, 0, 0, 0, 1, 4'(k), 0, 0, 0);
    for (int i = 0; i < 3; i++) st("os9_pause", 0, 0, 0, 1, 0, 1, 4'd4, 0, 0, 0);
    st("os9_resume", 0, 0, 0, 0, 0, 1, 4'd4, 0, 0, 0);
    for (int k = 5; k <= 9; k++) st("os9_run2", 0, 0, 0, 0, 0, 1, 4'(k), k == 9, 0, 0);
    st("os9_end", 0, 0, 0, 0, 0, 0, 4'd9, 0, 0, 0);
    // zero limit rejected
    st("err_pulse", 1, 4'd0, 1, 0, 0, 0, 4'd9, 0, 1, 0);
    st("err_clear", 0, 4'd0, 0, 0, 0, 0, 4'd9, 0, 0, 0);
    // periodic limit 15, restart attempt while busy, pause at terminal ignored
    st("p15_start", 1, 4'd15, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 15; k++)
      st("p15_run", k == 3, k == 3 ? 4'd2 : 4'd7, 0, 0, 0, 1, 4'(k), k == 15, 0, 0);
    st("p15_wrap", 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    st("p15_hold", 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    st("p15_resume", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    st("p15_count", 0, 0, 0, 0, 0, 1, 4'd1, 0, 0, 1);
    st("p15_pause", 0, 0, 0, 1, 0, 1, 4'd1, 0, 0, 1);
    st("hold_abort", 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    // period tally saturation with limit 1
    st("sat_start", 1, 4'd1, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 520; k++)
      st("sat_run", 0, 0, 0, 0, 0, 1, 4'(k % 2), (k % 2) == 1, 0, (k / 2) > 255 ? 8'd255 : 8'(k / 2));
    st("sat_abort", 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'd255);
    // periodic limit 12, async reset at cout 7 after one wrap
    st("p12_start", 1, 4'd12, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++)
      st("p12_run", 0, 0, 0, 0, 0, 1, 4'(k % 13), (k % 13) == 12, 0, 8'(k / 13));
    @(negedge clk);
    #2 reset = 1'b0;
    sb.push_back('{"async_rst", 15'd0});
    @(posedge clk);
    #1 reset = 1'b1;
    st("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
